// File: rtl/nr_pkg.sv
// Shared types and constants for the Newton-Raphson reciprocal refinement stage.
package nr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL_DX,
        MUL_XT,
        DONE
    } nr_state_e;

    // Iteration counter width; never narrower than one bit so N_ITER=0 still elaborates.
    function automatic int unsigned iter_w(input int unsigned n_iter);
        return (n_iter < 1) ? 1 : $clog2(n_iter + 1);
    endfunction

    // 2.0 expressed in Q2.(w-1).
    function automatic logic [31:0] two_q2(input int unsigned w);
        return 32'd2 << (w - 1);
    endfunction

endpackage

// File: rtl/nr_mul_trunc.sv
// Unsigned multiply, drop SHIFT low bits and optionally saturate at 2^SAT_W.
// With NR_ROUND_EN defined the drop is round-half-up instead of plain truncation.
module nr_mul_trunc #(
    parameter int unsigned A_W   = 9,
    parameter int unsigned B_W   = 10,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned OUT_W = 10,
    parameter int unsigned SAT_W = 9
) (
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             sat_en,
    output logic [OUT_W-1:0] y
);

    localparam int unsigned P_W = A_W + B_W + 1;

    logic [P_W-1:0] prod;
    logic [P_W-1:0] full;

    always_comb begin
        prod = P_W'(a) * P_W'(b);
`ifdef NR_ROUND_EN
        prod = prod + (P_W'(1) << (SHIFT - 1));
`endif
        full = prod >> SHIFT;
        if (sat_en && (full >= (P_W'(1) << SAT_W))) begin
            y = OUT_W'((P_W'(1) << SAT_W) - P_W'(1));
        end else begin
            y = full[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/nr_reciprocal_refine.sv
// Newton-Raphson reciprocal refinement x' = x*(2 - d*x) on one shared multiplier.
// Define NR_ROUND_EN to round-half-up both truncation steps.
module nr_reciprocal_refine
    import nr_pkg::*;
#(
    parameter int unsigned SIZE   = 4,
    parameter int unsigned W      = 3 * SIZE - 3,
    parameter int unsigned N_ITER = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] fraction,
    input  logic [W-1:0]    seed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    recip,
    output logic            div_by_zero
);

    localparam int unsigned ITER_W = iter_w(N_ITER);
    localparam logic [W:0]  TWO_Q2 = (W + 1)'(two_q2(W));

    nr_state_e         state;
    logic [SIZE-1:0]   d_r;
    logic [W-1:0]      x_r;
    logic [W:0]        t_r;
    logic [ITER_W-1:0] iter;
    logic              flag;

    logic              mul_sat;
    logic [W:0]        mul_b;
    logic [W:0]        mul_y;

    // d is pre-shifted into x's fraction alignment so both products drop W-1 bits.
    assign mul_sat = (state == MUL_XT);
    assign mul_b   = mul_sat ? t_r : ((W + 1)'(d_r) << (W - SIZE));

    nr_mul_trunc #(
        .A_W  (W),
        .B_W  (W + 1),
        .SHIFT(W - 1),
        .OUT_W(W + 1),
        .SAT_W(W)
    ) u_mul (
        .a     (x_r),
        .b     (mul_b),
        .sat_en(mul_sat),
        .y     (mul_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            recip       <= '0;
            div_by_zero <= 1'b0;
            iter        <= '0;
            d_r         <= '0;
            x_r         <= '0;
            t_r         <= '0;
            flag        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d_r      <= fraction;
                        x_r      <= fraction[SIZE-1] ? seed : '1;
                        iter     <= '0;
                        flag     <= ~fraction[SIZE-1];
                        in_ready <= 1'b0;
                        if (N_ITER == 0 || !fraction[SIZE-1]) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            recip       <= fraction[SIZE-1] ? seed : '1;
                            div_by_zero <= ~fraction[SIZE-1];
                        end else begin
                            state <= MUL_DX;
                        end
                    end
                end
                MUL_DX: begin
                    t_r   <= TWO_Q2 - mul_y;
                    state <= MUL_XT;
                end
                MUL_XT: begin
                    x_r  <= mul_y[W-1:0];
                    iter <= iter + ITER_W'(1);
                    if ((iter + ITER_W'(1)) == ITER_W'(N_ITER)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        recip       <= mul_y[W-1:0];
                        div_by_zero <= flag;
                    end else begin
                        state <= MUL_DX;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_reciprocal_refine.sv
// Self-checking bench: N_ITER=2 and N_ITER=0 instances against an arithmetic reference model.
module tb_nr_reciprocal_refine;

    localparam int unsigned SIZE = 4;
    localparam int unsigned W    = 9;
    localparam int unsigned N    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [SIZE-1:0] fraction;
    logic [W-1:0]    seed, recip;

    logic            in_valid_z, in_ready_z, out_valid_z, out_ready_z, div_by_zero_z;
    logic [SIZE-1:0] fraction_z;
    logic [W-1:0]    seed_z, recip_z;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    nr_reciprocal_refine #(.SIZE(SIZE), .W(W), .N_ITER(N)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fraction(fraction), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready),
        .recip(recip), .div_by_zero(div_by_zero)
    );

    nr_reciprocal_refine #(.SIZE(SIZE), .W(W), .N_ITER(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_z), .in_ready(in_ready_z),
        .fraction(fraction_z), .seed(seed_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z),
        .recip(recip_z), .div_by_zero(div_by_zero_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reciprocal refinement computed straight from the Q-format rules.
    function automatic logic [W-1:0] model(input logic [SIZE-1:0] d, input logic [W-1:0] s,
                                           input int unsigned n_iter);
        int unsigned x, p, t, q;
        if (!d[SIZE-1]) return '1;
        x = s;
        for (int unsigned i = 0; i < n_iter; i++) begin
            p = d * x;                       // Q2.(SIZE+W-2)
`ifdef NR_ROUND_EN
            p = p + (1 << (SIZE - 2));
`endif
            p = p >> (SIZE - 1);             // Q2.(W-1)
            t = ((2 << (W - 1)) - p) % (1 << (W + 1));
            q = x * t;                       // Q3.(2W-2)
`ifdef NR_ROUND_EN
            q = q + (1 << (W - 2));
`endif
            q = q >> (W - 1);
            x = (q >= (1 << W)) ? ((1 << W) - 1) : q;
        end
        return W'(x);
    endfunction

    task automatic run_op(input logic [SIZE-1:0] d, input logic [W-1:0] s, input int unsigned stall);
        int unsigned edges;
        logic [W-1:0] exp_r;
        exp_r = model(d, s, N);
        edges = 0;
        while (!in_ready && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        check("in_ready_before", in_ready, 1);
        fraction = d; seed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        fraction = SIZE'($urandom);
        seed     = W'($urandom);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        check("latency", edges, d[SIZE-1] ? (2 * N + 1) : 1);
        check("recip", recip, exp_r);
        check("div_by_zero", div_by_zero, !d[SIZE-1]);
        for (int unsigned i = 0; i < stall; i++) begin
            in_valid = (i == stall / 2);
            fraction = 4'b1100; seed = 9'd7;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_recip", recip, exp_r);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        in_valid = 0; out_ready = 0; fraction = '0; seed = '0;
        in_valid_z = 0; out_ready_z = 1; fraction_z = '0; seed_z = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_recip", recip, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_z_in_ready", in_ready_z, 1);
        check("rst_z_out_valid", out_valid_z, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run_op(4'b1100, 9'd160, 0);
`ifdef NR_ROUND_EN
        check("tp_1p5", recip, 171);
`else
        check("tp_1p5", recip, 170);
`endif
        run_op(4'b1000, 9'd256, 0);
        check("tp_1p0", recip, 256);
        run_op(4'b0000, 9'd100, 0);
        check("tp_dbz_recip", recip, 511);
        run_op(4'b0111, 9'd300, 0);
        run_op(4'b1111, 9'd511, 0);
        run_op(4'b1000, 9'd511, 0);
        run_op(4'b1100, 9'd160, 10);

        // Reset in MUL_XT of the first iteration
        fraction = 4'b1100; seed = 9'd160; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        run_op(4'b1100, 9'd160, 0);
`ifndef NR_ROUND_EN
        check("midrst_next", recip, 170);
`endif

        // Randomized operands
        for (int unsigned k = 0; k < 24; k++) begin
            logic [SIZE-1:0] d;
            d = SIZE'($urandom);
            if ($urandom_range(0, 5) != 0) d[SIZE-1] = 1'b1;
            run_op(d, W'($urandom), $urandom_range(0, 3));
        end

        // N_ITER=0 instance: out_ready tied high, in_valid held, one op per two cycles
        for (int unsigned k = 0; k < 8; k++) begin
            logic [SIZE-1:0] d;
            logic [W-1:0]    s;
            d = (k == 0) ? 4'b1100 : SIZE'($urandom);
            s = (k == 0) ? 9'd160 : W'($urandom);
            check("z_in_ready", in_ready_z, 1);
            fraction_z = d; seed_z = s; in_valid_z = 1'b1;
            @(posedge clk); #1;
            check("z_out_valid", out_valid_z, 1);
            check("z_recip", recip_z, model(d, s, 0));
            check("z_dbz", div_by_zero_z, !d[SIZE-1]);
            check("z_busy", in_ready_z, 0);
            fraction_z = SIZE'($urandom); seed_z = W'($urandom);
            @(posedge clk); #1;
            check("z_released", out_valid_z, 0);
        end
        in_valid_z = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
